// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regbank_arbiter
// Description : Round-robin arbiter that lets NUM_REQ requesters write into a
//               shared register bank. A requester may lock the arbiter so that
//               only it is granted until it releases the lock. Provides a
//               registered read port and a saturating write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic                        locked_o,
  output logic [OWN_W-1:0]            owner_o,
  output logic [7:0]                  wr_count_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [OWN_W-1:0]   owner;
  logic [OWN_W-1:0]   owner_nxt;
  logic [OWN_W-1:0]   rr_ptr;
  logic [OWN_W-1:0]   gnt_idx;
  logic [OWN_W-1:0]   cand;
  logic [NUM_REQ-1:0] ready;
  logic               xfer;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_in_range;
  logic               rd_in_range;
  logic [DATA_W-1:0]  bank [NUM_REGS];
  logic [DATA_W-1:0]  rd_data;
  logic [7:0]         wr_count;

  // Grant selection: owner-only while locked, otherwise first valid requester
  // at or above rr_ptr (wrapping). The loop runs from the farthest candidate
  // down to the nearest so the nearest valid one is the last to be assigned.
  always_comb begin
    ready   = '0;
    gnt_idx = '0;
    cand    = '0;
    if (reset) begin
      if (state == ST_LOCKED) begin
        ready[owner] = req_valid_i[owner];
        gnt_idx      = owner;
      end else begin
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          cand = OWN_W'((int'(rr_ptr) + i) % NUM_REQ);
          if (req_valid_i[cand]) begin
            ready       = '0;
            ready[cand] = 1'b1;
            gnt_idx     = cand;
          end
        end
      end
    end
  end

  assign xfer        = |ready;
  assign wr_addr     = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign wr_data     = req_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
  assign wr_in_range = (int'(wr_addr) < NUM_REGS);
  assign rd_in_range = (int'(rd_addr_i) < NUM_REGS);

  // Lock FSM next-state: enter on a locking transfer, leave once the owner
  // deasserts lock (with or without a final transfer).
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      ST_IDLE: begin
        if (xfer && req_lock_i[gnt_idx]) begin
          state_nxt = ST_LOCKED;
          owner_nxt = gnt_idx;
        end
      end
      ST_LOCKED: begin
        if (!req_lock_i[owner] && (xfer || !req_valid_i[owner])) begin
          state_nxt = ST_IDLE;
          owner_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = '0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Datapath: round-robin pointer, bank writes, write counter, read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr   <= '0;
      wr_count <= '0;
      rd_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      // Read samples the bank before this edge's write lands.
      rd_data <= rd_in_range ? bank[rd_addr_i] : '0;
      if (xfer) begin
        rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + OWN_W'(1);
        if (wr_in_range) begin
          bank[wr_addr] <= wr_data;
          if (wr_count != 8'hFF) begin
            wr_count <= wr_count + 8'd1;
          end
        end
      end
    end
  end

  assign req_ready_o = ready;
  assign rd_data_o   = rd_data;
  assign locked_o    = (state == ST_LOCKED);
  assign owner_o     = owner;
  assign wr_count_o  = wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_arbiter
// Description : Scoreboard bench for regbank_arbiter. A five-entry bank is
//               used so that 3-bit addresses 5..7 are out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int OWN_W    = $clog2(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_lock_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [ADDR_W-1:0]         rd_addr_i;
  logic [DATA_W-1:0]         rd_data_o;
  logic                      locked_o;
  logic [OWN_W-1:0]          owner_o;
  logic [7:0]                wr_count_o;

  regbank_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid_i),
    .req_lock_i (req_lock_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .locked_o   (locked_o),
    .owner_o    (owner_o),
    .wr_count_o (wr_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] ready;
    logic               locked;
    logic [OWN_W-1:0]   owner;
    logic [7:0]         count;
    logic [DATA_W-1:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model state
  int m_ptr, m_locked, m_owner, m_count, m_rd;
  int m_bank [NUM_REGS];

  // Stimulus for the next cycle
  bit s_rst;
  bit [NUM_REQ-1:0] s_valid, s_lock;
  int s_addr [NUM_REQ];
  int s_data [NUM_REQ];
  int s_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0; m_count = 0; m_rd = 0;
    for (int i = 0; i < NUM_REGS; i++) m_bank[i] = 0;
  endtask

  // Drive one cycle, push the model's expectation, advance the model.
  task automatic step();
    exp_t e;
    int   g;
    int   c;
    int   nrd;
    reset       = s_rst;
    req_valid_i = s_valid;
    req_lock_i  = s_lock;
    rd_addr_i   = ADDR_W'(s_rd);
    for (int k = 0; k < NUM_REQ; k++) begin
      req_addr_i[k*ADDR_W +: ADDR_W] = ADDR_W'(s_addr[k]);
      req_data_i[k*DATA_W +: DATA_W] = DATA_W'(s_data[k]);
    end
    g = -1;
    if (s_rst) begin
      if (m_locked != 0) begin
        if (s_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (g < 0 && s_valid[c]) g = c;
        end
      end
    end
    e.ready  = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    e.locked = (m_locked != 0);
    e.owner  = OWN_W'(m_owner);
    e.count  = 8'(m_count);
    e.rd     = DATA_W'(m_rd);
    sb.push_back(e);

    if (!s_rst) begin
      model_reset();
    end else begin
      nrd = (s_rd < NUM_REGS) ? m_bank[s_rd] : 0;
      if (g >= 0) begin
        if (s_addr[g] < NUM_REGS) begin
          m_bank[s_addr[g]] = s_data[g] & 8'hFF;
          if (m_count < 255) m_count++;
        end
        m_ptr = (g + 1) % NUM_REQ;
      end
      if (m_locked == 0) begin
        if (g >= 0 && s_lock[g]) begin
          m_locked = 1; m_owner = g;
        end
      end else if (!s_lock[m_owner]) begin
        m_locked = 0; m_owner = 0;
      end
      m_rd = nrd;
    end
    @(posedge clk); #1;
  endtask

  task automatic set(input bit [NUM_REQ-1:0] v, input bit [NUM_REQ-1:0] lk);
    s_valid = v;
    s_lock  = lk;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ready",    32'(req_ready_o), 32'(e.ready));
        chk("locked",   32'(locked_o),    32'(e.locked));
        chk("owner",    32'(owner_o),     32'(e.owner));
        chk("wr_count", 32'(wr_count_o),  32'(e.count));
        chk("rd_data",  32'(rd_data_o),   32'(e.rd));
        for (int k = 0; k < NUM_REQ; k++)
          if (req_ready_o[k] === 1'b1 && req_valid_i[k] === 1'b1) glog.push_back(k);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_lk [6] = '{1, 1, 1, 1, 1, 2};

    // Initial reset
    reset = 1'b0; req_valid_i = '0; req_lock_i = '0;
    req_addr_i = '0; req_data_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk); #1;
    model_reset();
    s_rst = 1'b0; set('0, '0); s_rd = 0;
    for (int k = 0; k < NUM_REQ; k++) begin s_addr[k] = k; s_data[k] = 8'h10 + k; end
    step();
    chk("reset_locked", 32'(locked_o), 0);
    chk("reset_owner",  32'(owner_o), 0);
    chk("reset_count",  32'(wr_count_o), 0);
    chk("reset_rd",     32'(rd_data_o), 0);

    // Round-robin with all requesters valid
    s_rst = 1'b1; set(4'b1111, 4'b0000); glog.delete();
    repeat (8) step();
    chk("rr_n_grants", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_grant", glog[i], exp_rr[i]);
    chk("rr_count", 32'(wr_count_o), 8);

    // Write/read with same-cycle read returning the old value
    s_rst = 1'b0; set('0, '0); step();
    s_rst = 1'b1; set(4'b0100, 4'b0000); s_addr[2] = 3; s_data[2] = 8'hA5; s_rd = 3;
    step();
    chk("same_cycle_read", 32'(rd_data_o), 0);
    set('0, '0); step();
    chk("read_after_write", 32'(rd_data_o), 32'hA5);

    // Lock by requester 1 while others are valid
    s_rst = 1'b0; set('0, '0); step();
    s_rst = 1'b1; set(4'b0001, 4'b0000); step();
    glog.delete();
    set(4'b1111, 4'b0010); step();
    repeat (3) step();
    chk("lock_locked", 32'(locked_o), 1);
    chk("lock_owner",  32'(owner_o), 1);
    set(4'b1111, 4'b0000); step();
    chk("unlock_locked", 32'(locked_o), 0);
    chk("unlock_owner",  32'(owner_o), 0);
    step();
    chk("lock_n_grants", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("lock_grant", glog[i], exp_lk[i]);

    // Lock abandon: owner drops valid and lock together
    set(4'b1000, 4'b1000); step();
    chk("abandon_locked", 32'(locked_o), 1);
    chk("abandon_owner",  32'(owner_o), 3);
    glog.delete();
    set(4'b0111, 4'b0000); step();
    chk("abandon_unlocked", 32'(locked_o), 0);
    step();
    chk("abandon_n_grants", glog.size(), 1);
    if (glog.size() > 0) chk("abandon_grant", glog[0], 0);

    // Reset while locked with data pending
    set(4'b0100, 4'b0100); step();
    chk("midlock_locked", 32'(locked_o), 1);
    glog.delete();
    s_rst = 1'b0; set(4'b1111, 4'b0100); step();
    chk("midlock_no_ready", glog.size(), 0);
    chk("midlock_locked_cleared", 32'(locked_o), 0);
    chk("midlock_count_cleared", 32'(wr_count_o), 0);
    s_rst = 1'b1; set('0, '0);
    for (int a = 0; a < NUM_REGS; a++) begin
      s_rd = a; step();
      chk("midlock_bank_zero", 32'(rd_data_o), 0);
    end
    set(4'b0110, 4'b0000); step();
    chk("midlock_n_grants", glog.size(), 1);
    if (glog.size() > 0) chk("midlock_grant", glog[0], 1);

    // Randomized traffic, including out-of-range addresses and resets
    for (int n = 0; n < 300; n++) begin
      s_rst   = ($urandom_range(0, 39) != 0);
      s_valid = NUM_REQ'($urandom);
      s_lock  = NUM_REQ'($urandom & $urandom);
      for (int k = 0; k < NUM_REQ; k++) begin
        s_addr[k] = $urandom_range(0, 7);
        s_data[k] = $urandom_range(0, 255);
      end
      s_rd = $urandom_range(0, 7);
      step();
    end

    // Counter saturation, then an out-of-range write
    s_rst = 1'b0; set('0, '0); step();
    s_rst = 1'b1; set(4'b0001, 4'b0000); s_addr[0] = 2;
    for (int n = 0; n < 260; n++) begin
      s_data[0] = $urandom_range(0, 255);
      step();
    end
    chk("sat_count", 32'(wr_count_o), 255);
    s_addr[0] = 6; s_data[0] = 8'h3C; step();
    chk("oor_count", 32'(wr_count_o), 255);
    set('0, '0);
    for (int a = 0; a < NUM_REGS + 2; a++) begin
      s_rd = a; step();
    end
    step();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
